// File: rtl/polyshift_seq.sv
// Multi-word left-shift sequencer: buffers an operand low word first, then streams
// the shifted words back out, chaining carry bits from each word into the next.
package polyshift_pkg;
    localparam logic [1:0] SHIFT_LOGIC = 2'd0;
    localparam logic [1:0] SHIFT_ARITH = 2'd1;
    localparam logic [1:0] SHIFT_RCL   = 2'd2;
    localparam logic [1:0] SHIFT_ROL   = 2'd3;
endpackage

// Single-word left shifter. D_OUT takes the top shift_size bits of the selected carry
// source into its low end; C_OUT holds the bits pushed out of the top, right-aligned.
module polyshift_l #(
    parameter int word_width = 8
) (
    input  logic [1:0]                    shift_type,
    input  logic [word_width-1:0]         D_IN,
    input  logic [$clog2(word_width)-1:0] shift_size,
    input  logic [word_width-2:0]         C_IN,
    output logic [word_width-1:0]         D_OUT,
    output logic [word_width-2:0]         C_OUT
);
    import polyshift_pkg::*;

    logic [word_width-2:0]   carry;
    logic [2*word_width-2:0] cat_sh;
    logic [2*word_width-2:0] ext_sh;

    always_comb begin
        carry = '0;
        case (shift_type)
            SHIFT_RCL: carry = C_IN;
            SHIFT_ROL: carry = D_IN[word_width-1:1];
            default:   carry = '0;
        endcase
    end

    // Shifting {data, carry} as one vector pulls the top carry bits in below the data.
    assign cat_sh = {D_IN, carry} << shift_size;
    assign ext_sh = {{(word_width-1){1'b0}}, D_IN} << shift_size;
    assign D_OUT  = cat_sh[2*word_width-2 -: word_width];
    assign C_OUT  = ext_sh[2*word_width-2 -: word_width-1];
endmodule

module polyshift_seq #(
    parameter int word_width = 8,
    parameter int max_words  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             START,
    input  logic [$clog2(max_words+1)-1:0]   WORDS,
    input  logic [$clog2(word_width)-1:0]    SHIFT_SIZE,
    input  logic [1:0]                       SHIFT_TYPE_IN,
    input  logic [word_width-2:0]            C_FILL,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [word_width-1:0]            IN_DATA,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [word_width-1:0]            OUT_DATA,
    output logic [word_width-2:0]            SPILL,
    output logic                             BUSY,
    output logic                             DONE
);
    // state | meaning
    // IDLE  | waiting for START
    // LOAD  | accepting operand words into the buffer
    // EMIT  | streaming shifted words out
    // FIN   | one-cycle DONE pulse
    import polyshift_pkg::*;

    localparam int WW = $clog2(max_words+1);
    localparam int IW = $clog2(max_words);
    localparam int SW = $clog2(word_width);
    localparam logic [WW-1:0] MAXW = WW'(max_words);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, FIN} state_t;

    state_t                state, state_nxt;
    logic [word_width-1:0] data_buf [max_words];
    logic [IW-1:0]         idx, idx_m1, last_q;
    logic [SW-1:0]         sh_q;
    logic [1:0]            typ_q;
    logic [word_width-2:0] cfill_q, spill_q, carry_in, core_cout;
    logic [word_width-1:0] core_din, core_dout;
    logic [WW-1:0]         words_clamp;
    logic                  in_hs, out_hs, at_last;

    assign in_hs       = IN_VALID & IN_READY;
    assign out_hs      = OUT_VALID & OUT_READY;
    assign at_last     = (idx == last_q);
    assign idx_m1      = idx - 1'b1;
    assign words_clamp = (WORDS > MAXW) ? MAXW : WORDS;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (START) state_nxt = (WORDS == '0) ? FIN : LOAD;
            LOAD: if (in_hs && at_last) state_nxt = EMIT;
            EMIT: if (out_hs && at_last) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        case (state)
            IDLE:    BUSY      = 1'b0;
            LOAD:    IN_READY  = 1'b1;
            EMIT:    OUT_VALID = 1'b1;
            FIN:     DONE      = 1'b1;
            default: BUSY      = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            last_q  <= '0;
            sh_q    <= '0;
            typ_q   <= '0;
            cfill_q <= '0;
            spill_q <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    sh_q    <= SHIFT_SIZE;
                    typ_q   <= SHIFT_TYPE_IN;
                    cfill_q <= C_FILL;
                    last_q  <= IW'(words_clamp - 1'b1);
                    idx     <= '0;
                    spill_q <= '0;
                end
                LOAD: if (in_hs) begin
                    if (at_last) begin
                        idx     <= '0;
                        spill_q <= core_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: if (out_hs) idx <= at_last ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD && in_hs) data_buf[idx] <= IN_DATA;
    end

    // Word 0 has no word below it, so its carry source depends on the shift type.
    always_comb begin
        carry_in = '0;
        if (idx != '0) begin
            carry_in = data_buf[idx_m1][word_width-1:1];
        end else begin
            case (typ_q)
                SHIFT_RCL: carry_in = cfill_q;
                SHIFT_ROL: carry_in = data_buf[last_q][word_width-1:1];
                default:   carry_in = '0;
            endcase
        end
    end

    // During LOAD the core sees the incoming word so its carry-out yields the spill bits.
    assign core_din = (state == LOAD) ? IN_DATA : data_buf[idx];

    polyshift_l #(.word_width(word_width)) u_core (
        .shift_type (SHIFT_RCL),
        .D_IN       (core_din),
        .shift_size (sh_q),
        .C_IN       (carry_in),
        .D_OUT      (core_dout),
        .C_OUT      (core_cout)
    );

    assign OUT_DATA = core_dout;
    assign SPILL    = spill_q;
endmodule

// File: tb/tb_polyshift_seq.sv
// Self-checking bench for polyshift_seq: table-driven runs with a scoreboard queue,
// plus backpressure, reset-mid-load and zero-length sequences.
module tb_polyshift_seq;
    import polyshift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, START, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY, DONE;
    logic [2:0] WORDS, SHIFT_SIZE;
    logic [1:0] SHIFT_TYPE_IN;
    logic [6:0] C_FILL, SPILL;
    logic [7:0] IN_DATA, OUT_DATA;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    polyshift_seq #(.word_width(8), .max_words(4)) dut (
        .clk(clk), .rst_n(rst_n), .START(START), .WORDS(WORDS), .SHIFT_SIZE(SHIFT_SIZE),
        .SHIFT_TYPE_IN(SHIFT_TYPE_IN), .C_FILL(C_FILL), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .IN_DATA(IN_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .SPILL(SPILL), .BUSY(BUSY), .DONE(DONE)
    );

    typedef struct packed {
        logic [1:0]      typ;
        logic [2:0]      s;
        logic [2:0]      words;
        logic [6:0]      cfill;
        logic [3:0][7:0] din;
        logic [3:0][7:0] dout;
        logic [6:0]      spill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] typ, input logic [2:0] s, input logic [2:0] w,
                                input logic [6:0] cf, input logic [31:0] din,
                                input logic [31:0] dout, input logic [6:0] sp);
        vec_t v;
        v.typ = typ; v.s = s; v.words = w; v.cfill = cf;
        v.din = din; v.dout = dout; v.spill = sp;
        return v;
    endfunction

    task automatic run(input vec_t v, input int stall_at, input int stall_n);
        int nw, got, cyc, stall_left;
        nw = (v.words > 3'd4) ? 4 : int'(v.words);
        stall_left = stall_n;
        @(negedge clk);
        START = 1'b1; WORDS = v.words; SHIFT_SIZE = v.s;
        SHIFT_TYPE_IN = v.typ; C_FILL = v.cfill;
        @(negedge clk);
        START = 1'b0; WORDS = 3'd0; SHIFT_SIZE = ~v.s;
        SHIFT_TYPE_IN = ~v.typ; C_FILL = ~v.cfill;
        chk("busy_load", BUSY, 1);
        OUT_READY = 1'b1;
        for (int i = 0; i < nw; i++) begin
            IN_VALID = 1'b1; IN_DATA = v.din[i];
            chk("in_ready", IN_READY, 1);
            chk("out_valid_load", OUT_VALID, 0);
            exp_q.push_back(v.dout[i]);
            @(negedge clk);
        end
        IN_VALID = 1'b0; IN_DATA = 8'($urandom);
        chk("spill", SPILL, v.spill);
        got = 0; cyc = 0;
        while (got < nw && cyc < 40) begin
            if (got == stall_at && stall_left > 0) begin
                OUT_READY = 1'b0; START = 1'b1; stall_left--;
                chk("stall_valid", OUT_VALID, 1);
                chk("stall_data", OUT_DATA, exp_q[0]);
            end else begin
                OUT_READY = 1'b1; START = 1'b0;
            end
            if (OUT_VALID && OUT_READY) begin
                chk("out_data", OUT_DATA, exp_q.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        OUT_READY = 1'b0; START = 1'b0;
        if (got < nw) begin
            chk("emit_timeout", got, nw);
            exp_q.delete();
        end
        chk("done_pulse", DONE, 1);
        chk("out_valid_fin", OUT_VALID, 0);
        @(negedge clk);
        chk("done_low", DONE, 0);
        chk("busy_idle", BUSY, 0);
        chk("spill_hold", SPILL, v.spill);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = mk(SHIFT_LOGIC, 3'd1, 3'd2, 7'h00, 32'h0000C381, 32'h00008702, 7'h01);
        vecs[1] = mk(SHIFT_ROL,   3'd1, 3'd2, 7'h00, 32'h0000C381, 32'h00008703, 7'h01);
        vecs[2] = mk(SHIFT_RCL,   3'd3, 3'd2, 7'h55, 32'h0000C381, 32'h00001C0D, 7'h06);
        vecs[3] = mk(SHIFT_ARITH, 3'd0, 3'd4, 7'h7F, 32'h44332211, 32'h44332211, 7'h00);
        vecs[4] = mk(SHIFT_ROL,   3'd3, 3'd1, 7'h00, 32'h00000081, 32'h0000000C, 7'h04);
        vecs[5] = mk(SHIFT_LOGIC, 3'd4, 3'd7, 7'h7F, 32'h78563412, 32'h85634120, 7'h07);
        vecs[6] = mk(SHIFT_ARITH, 3'd1, 3'd2, 7'h7F, 32'h0000C381, 32'h00008702, 7'h01);
        vecs[7] = mk(SHIFT_RCL,   3'd7, 3'd3, 7'h40, 32'h008001FF, 32'h0000FFC0, 7'h40);
        vecs[8] = mk(SHIFT_ROL,   3'd2, 3'd4, 7'h00, 32'hC0400281, 32'h01000A07, 7'h03);

        rst_n = 1'b0; START = 1'b0; WORDS = '0; SHIFT_SIZE = '0; SHIFT_TYPE_IN = '0;
        C_FILL = '0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_spill", SPILL, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run(vecs[i], -1, 0);

        // Backpressure on word 1 with a stray START during EMIT.
        run(vecs[0], 1, 3);

        // Reset in the middle of LOAD after one word.
        @(negedge clk);
        START = 1'b1; WORDS = 3'd3; SHIFT_SIZE = 3'd1; SHIFT_TYPE_IN = SHIFT_LOGIC;
        @(negedge clk);
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = 8'hAA;
        @(negedge clk);
        IN_VALID = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", IN_READY, 0);
        chk("mid_rst_out_valid", OUT_VALID, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_spill", SPILL, 0);
        rst_n = 1'b1;

        // Zero-length run: straight to FIN, input stays closed.
        @(negedge clk);
        START = 1'b1; WORDS = 3'd0; IN_VALID = 1'b1;
        chk("w0_in_ready_start", IN_READY, 0);
        @(negedge clk);
        START = 1'b0;
        chk("w0_done", DONE, 1);
        chk("w0_out_valid", OUT_VALID, 0);
        chk("w0_in_ready", IN_READY, 0);
        chk("w0_spill", SPILL, 0);
        @(negedge clk);
        IN_VALID = 1'b0;
        chk("w0_done_low", DONE, 0);
        chk("w0_busy", BUSY, 0);
        chk("w0_in_ready_after", IN_READY, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
